// File: rtl/motion_pkg.sv
// Shared types for the motion-detect / box-overlay custom instructions.
package motion_pkg;

   localparam int unsigned X_W              = 10;
   localparam int unsigned Y_W              = 9;
   localparam int unsigned FRAME_WIDTH_DEF  = 640;
   localparam int unsigned FRAME_HEIGHT_DEF = 480;

   typedef enum logic [1:0] {
      OP_PIXEL   = 2'd0,
      OP_SETX    = 2'd1,
      OP_SETY    = 2'd2,
      OP_RESTART = 2'd3
   } op_e;

   typedef struct packed {
      logic [X_W-1:0] min_x;
      logic [X_W-1:0] max_x;
      logic [Y_W-1:0] min_y;
      logic [Y_W-1:0] max_y;
   } box_t;

   // min > max on both axes: no pixel is ever inside, so nothing is drawn.
   localparam box_t BOX_EMPTY = '{min_x: 10'd1023, max_x: 10'd0,
                                  min_y: 9'd511,   max_y: 9'd0};

endpackage

// File: rtl/box_edge_test.sv
// Combinational outline test for one pixel against a bounding box.
module box_edge_test
   import motion_pkg::*;
#(
   parameter int unsigned BORDER = 2
) (
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] y,
   input  box_t           box,
   output logic           on_border
);

   logic           valid_c;
   logic           inside_c;
   logic [X_W-1:0] dx_lo_c;
   logic [X_W-1:0] dx_hi_c;
   logic [Y_W-1:0] dy_lo_c;
   logic [Y_W-1:0] dy_hi_c;

   // Differences only matter once containment holds, so wraparound is harmless.
   assign valid_c  = (box.min_x <= box.max_x) && (box.min_y <= box.max_y);
   assign inside_c = (x >= box.min_x) && (x <= box.max_x) &&
                     (y >= box.min_y) && (y <= box.max_y);
   assign dx_lo_c  = x - box.min_x;
   assign dx_hi_c  = box.max_x - x;
   assign dy_lo_c  = y - box.min_y;
   assign dy_hi_c  = box.max_y - y;

   // Pixel is on the outline when it lies within BORDER of any box edge.
   always_comb begin
      on_border = 1'b0;
      if (valid_c && inside_c) begin
         on_border = (dx_lo_c < X_W'(BORDER)) || (dx_hi_c < X_W'(BORDER)) ||
                     (dy_lo_c < Y_W'(BORDER)) || (dy_hi_c < Y_W'(BORDER));
      end
   end

endmodule

// File: rtl/motion_box_overlay.sv
// Paints a motion bounding-box outline into a streamed 4-pixel-per-word grayscale frame.
module motion_box_overlay
   import motion_pkg::*;
#(
   parameter logic [7:0]  customInstructionId = 8'd2,
   parameter int unsigned FRAME_WIDTH         = FRAME_WIDTH_DEF,
   parameter int unsigned FRAME_HEIGHT        = FRAME_HEIGHT_DEF,
   parameter int unsigned BORDER              = 2,
   parameter logic [7:0]  BOX_GRAY            = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  iseId,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result
);

   logic [X_W-1:0] pos_x;
   logic [Y_W-1:0] pos_y;
   box_t           shadow_box;
   box_t           act_box;

   logic           s1_valid;
   op_e            s1_op;
   logic [31:0]    s1_data;
   logic [3:0]     s1_flags;
   logic           s2_valid;
   logic [31:0]    s2_word;

   logic           busy_c;
   logic           accept_c;
   op_e            op_c;
   logic [3:0]     flags_c;
   logic [31:0]    overlay_c;
   logic [X_W:0]   pos_x_inc_c;
   logic [Y_W:0]   pos_y_inc_c;
   logic           row_end_c;
   logic           frame_end_c;
   logic           unused_c;

   assign busy_c      = s1_valid | s2_valid;
   assign accept_c    = start && (iseId == customInstructionId) && !busy_c;
   assign op_c        = op_e'(valueA[1:0]);
   assign pos_x_inc_c = (X_W+1)'(pos_x) + (X_W+1)'(4);
   assign pos_y_inc_c = (Y_W+1)'(pos_y) + (Y_W+1)'(1);
   assign row_end_c   = (pos_x_inc_c == (X_W+1)'(FRAME_WIDTH));
   assign frame_end_c = row_end_c && (pos_y_inc_c == (Y_W+1)'(FRAME_HEIGHT));
   assign unused_c    = ^valueA[31:2];

   // One outline tester per pixel lane; lane i covers x = pos_x + i.
   for (genvar i = 0; i < 4; i++) begin : g_edge
      box_edge_test #(.BORDER(BORDER)) u_edge (
         .x        (pos_x + X_W'(i)),
         .y        (pos_y),
         .box      (act_box),
         .on_border(flags_c[i])
      );
   end

   // Replace flagged lanes with the outline gray; lane 0 is the top byte.
   always_comb begin
      overlay_c = s1_data;
      for (int i = 0; i < 4; i++) begin
         if (s1_flags[i]) overlay_c[31-8*i -: 8] = BOX_GRAY;
      end
   end

   // Position counters and shadow/active box; commits happen at acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_x      <= '0;
         pos_y      <= '0;
         shadow_box <= BOX_EMPTY;
         act_box    <= BOX_EMPTY;
      end else if (accept_c) begin
         case (op_c)
            OP_PIXEL: begin
               if (row_end_c) begin
                  pos_x <= '0;
                  if (frame_end_c) begin
                     pos_y   <= '0;
                     act_box <= shadow_box;
                  end else begin
                     pos_y <= pos_y_inc_c[Y_W-1:0];
                  end
               end else begin
                  pos_x <= pos_x_inc_c[X_W-1:0];
               end
            end
            OP_SETX: begin
               shadow_box.min_x <= valueB[9:0];
               shadow_box.max_x <= valueB[25:16];
            end
            OP_SETY: begin
               shadow_box.min_y <= valueB[8:0];
               shadow_box.max_y <= valueB[24:16];
            end
            OP_RESTART: begin
               pos_x   <= '0;
               pos_y   <= '0;
               act_box <= shadow_box;
            end
            default: ;
         endcase
      end
   end

   // Two-stage valid pipe: flags at acceptance, overlay next, registered output last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_PIXEL;
         s1_data  <= '0;
         s1_flags <= '0;
         s2_valid <= 1'b0;
         s2_word  <= '0;
         done     <= 1'b0;
         result   <= '0;
      end else begin
         s1_valid <= accept_c;
         if (accept_c) begin
            s1_op    <= op_c;
            s1_data  <= valueB;
            s1_flags <= flags_c;
         end
         s2_valid <= s1_valid;
         s2_word  <= (s1_valid && s1_op == OP_PIXEL) ? overlay_c : 32'h0;
         done     <= s2_valid;
         result   <= s2_valid ? s2_word : 32'h0;
      end
   end

endmodule

// File: tb/tb_motion_box_overlay.sv
// Randomized bench for motion_box_overlay against a per-pixel behavioural model.
module tb_motion_box_overlay;
   import motion_pkg::*;

   localparam int FW = 32;
   localparam int FH = 8;
   localparam int B  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  iseId = 8'd0;
   logic [31:0] valueA = 32'd0;
   logic [31:0] valueB = 32'd0;
   logic        done;
   logic [31:0] result;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // Model state: position, boxes as {minx,maxx,miny,maxy}, last accept edge.
   int m_px, m_py, m_last;
   int m_act [4];
   int m_sh  [4];
   logic [31:0] exp_res [int];

   motion_box_overlay #(
      .customInstructionId(8'd2),
      .FRAME_WIDTH        (FW),
      .FRAME_HEIGHT       (FH),
      .BORDER             (B),
      .BOX_GRAY           (8'hFF)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .iseId (iseId),
      .valueA(valueA),
      .valueB(valueB),
      .done  (done),
      .result(result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_px = 0; m_py = 0; m_last = -100;
      m_act = '{1023, 0, 511, 0};
      m_sh  = '{1023, 0, 511, 0};
      exp_res.delete();
   endtask

   function automatic logic [31:0] model_pixel(input logic [31:0] d);
      logic [31:0] w;
      int x, y;
      bit valid, on;
      w = d;
      y = m_py;
      valid = (m_act[0] <= m_act[1]) && (m_act[2] <= m_act[3]);
      for (int i = 0; i < 4; i++) begin
         x = m_px + i;
         on = valid && x >= m_act[0] && x <= m_act[1] && y >= m_act[2] && y <= m_act[3] &&
              ((x - m_act[0] < B) || (m_act[1] - x < B) || (y - m_act[2] < B) || (m_act[3] - y < B));
         if (on) w[31-8*i -: 8] = 8'hFF;
      end
      return w;
   endfunction

   // Apply one start sampled at edge k to the model and schedule its output.
   task automatic model_start(input logic [1:0] op, input logic [31:0] d, input logic [7:0] id, input int k);
      if (id != 8'd2 || k - m_last < 3) return;
      m_last = k;
      case (op)
         2'd0: begin
            exp_res[k+2] = model_pixel(d);
            m_px += 4;
            if (m_px == FW) begin
               m_px = 0;
               m_py++;
               if (m_py == FH) begin
                  m_py = 0;
                  m_act = m_sh;
               end
            end
         end
         2'd1: begin
            exp_res[k+2] = 32'h0;
            m_sh[0] = int'(d[9:0]);
            m_sh[1] = int'(d[25:16]);
         end
         2'd2: begin
            exp_res[k+2] = 32'h0;
            m_sh[2] = int'(d[8:0]);
            m_sh[3] = int'(d[24:16]);
         end
         default: begin
            exp_res[k+2] = 32'h0;
            m_px = 0; m_py = 0;
            m_act = m_sh;
         end
      endcase
   endtask

   // Every cycle: done and result must match what the model scheduled.
   always @(negedge clk) begin
      logic        ed;
      logic [31:0] er;
      ed = exp_res.exists(cyc);
      er = ed ? exp_res[cyc] : 32'h0;
      check("done", 32'(done), 32'(ed));
      check("result", result, er);
      if (ed) exp_res.delete(cyc);
   end

   task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [7:0] id);
      logic [31:0] r;
      @(posedge clk); #1;
      r = $urandom();
      start  = 1'b1;
      iseId  = id;
      valueA = {r[31:2], op};
      valueB = d;
      model_start(op, d, id, cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   // Issue one op, wait (bounded) for its done, optionally pin the result to a literal.
   task automatic op_wait(input logic [1:0] op, input logic [31:0] d, input bit chk,
                          input logic [31:0] lit, input string name);
      bit got;
      logic [31:0] r;
      got = 1'b0;
      r = 32'h0;
      drive(op, d, 8'd2);
      idle(1);
      for (int i = 0; i < 5 && !got; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            r = result;
         end
      end
      if (!got) begin
         compared++;
         mismatched++;
         $display("FAIL %s: no done within 5 cycles", name);
      end else if (chk) begin
         check(name, r, lit);
      end
   endtask

   task automatic pixels(input int n);
      for (int i = 0; i < n; i++) op_wait(2'd0, 32'h11223344, 1'b0, 32'h0, "pix");
   endtask

   initial begin
      logic [31:0] d;
      int r, gap;
      model_reset();
      idle(3);
      check("reset_done", 32'(done), 32'h0);
      check("reset_result", result, 32'h0);
      check("reset_posx", 32'(dut.pos_x), 32'h0);
      rst = 1'b0;
      idle(2);

      // Basic PIXEL with empty box
      op_wait(2'd0, 32'h11223344, 1'b1, 32'h11223344, "t1_pixel");
      check("t1_posx", 32'(dut.pos_x), 32'd4);

      // Box x 4..11, y 0..3 committed by RESTART
      op_wait(2'd1, (32'd11 << 16) | 32'd4, 1'b1, 32'h0, "t2_setx");
      op_wait(2'd2, (32'd3 << 16) | 32'd0, 1'b1, 32'h0, "t2_sety");
      op_wait(2'd3, 32'h0, 1'b1, 32'h0, "t2_restart");
      op_wait(2'd0, 32'h11223344, 1'b1, 32'h11223344, "t2_x0");
      op_wait(2'd0, 32'h11223344, 1'b1, 32'hFFFFFFFF, "t2_x4");

      // Taller box y 0..7: row 2 shows only the vertical edges
      op_wait(2'd2, (32'd7 << 16) | 32'd0, 1'b1, 32'h0, "t3_sety");
      op_wait(2'd3, 32'h0, 1'b1, 32'h0, "t3_restart");
      pixels(16 + 1);
      op_wait(2'd0, 32'h11223344, 1'b1, 32'hFFFF3344, "t3_row2_x4");
      op_wait(2'd0, 32'h11223344, 1'b1, 32'h1122FFFF, "t3_row2_x8");

      // Mid-frame SETX stays in shadow until the frame wraps
      op_wait(2'd1, (32'd23 << 16) | 32'd16, 1'b1, 32'h0, "t4_setx");
      pixels(6);
      op_wait(2'd0, 32'h11223344, 1'b1, 32'hFFFF3344, "t4_row3_x4_old");
      pixels(38);
      op_wait(2'd0, 32'h11223344, 1'b1, 32'h11223344, "t4_next_x0");
      check("t4_posy_wrap", 32'(dut.pos_y), 32'h0);
      op_wait(2'd0, 32'h11223344, 1'b1, 32'h11223344, "t4_next_x4");
      pixels(2);
      op_wait(2'd0, 32'h11223344, 1'b1, 32'hFFFFFFFF, "t4_next_x16");

      // Wrong ID, then starts while busy
      drive(2'd0, 32'hDEADBEEF, 8'd1);
      drive(2'd0, 32'h01020304, 8'd2);
      drive(2'd0, 32'h05060708, 8'd2);
      drive(2'd0, 32'h090A0B0C, 8'd2);
      idle(6);
      check("t5_posx", 32'(dut.pos_x), 32'(m_px));

      // Reset one cycle after a PIXEL start drops it
      drive(2'd0, 32'h11223344, 8'd2);
      idle(1);
      rst = 1'b1;
      model_reset();
      idle(2);
      check("t6_posx", 32'(dut.pos_x), 32'h0);
      check("t6_act_empty", 32'(dut.act_box == BOX_EMPTY), 32'h1);
      check("t6_shadow_empty", 32'(dut.shadow_box == BOX_EMPTY), 32'h1);
      rst = 1'b0;
      idle(2);
      op_wait(2'd0, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, "t6_after");

      // Random mix with random gaps
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 99);
         d = $urandom();
         if (r < 70) begin
            drive(2'd0, d, 8'd2);
         end else if (r < 78) begin
            if ($urandom_range(0, 3) != 0) begin
               d[9:0]   = 10'($urandom_range(0, FW + 3));
               d[25:16] = 10'($urandom_range(0, FW + 3));
            end
            drive(2'd1, d, 8'd2);
         end else if (r < 86) begin
            if ($urandom_range(0, 3) != 0) begin
               d[8:0]   = 9'($urandom_range(0, FH + 2));
               d[24:16] = 9'($urandom_range(0, FH + 2));
            end
            drive(2'd2, d, 8'd2);
         end else if (r < 90) begin
            drive(2'd3, d, 8'd2);
         end else begin
            drive(2'($urandom_range(0, 3)), d, 8'($urandom_range(3, 255)));
         end
         gap = $urandom_range(0, 3);
         if (gap > 0) idle(gap);
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
